// File: rtl/audio_arb_pkg.sv
// ----------------------------------------------------------------------------
// audio_arb_pkg
// Shared types and helpers for the audio stream arbiter.
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
//   STAT_W      : width of the per-source accepted-word counters
//   sat_inc     : saturating increment used by the statistics counters
// ----------------------------------------------------------------------------
package audio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
        logic [STAT_W-1:0] res;
        if (val == {STAT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_stream_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_SRC. Indices >= NUM_SRC are never produced.
// Ports:
//   req     in   NUM_SRC  request vector
//   ptr     in   ID_W     search start index (always < NUM_SRC)
//   gnt_id  out  ID_W     selected index (0 when nothing requested)
//   gnt_any out  1        at least one request present
// ----------------------------------------------------------------------------
module rr_pick
    import audio_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    // Priority search over rotated offsets; the first hit wins.
    always_comb begin
        int idx_v;
        idx_v   = 0;
        gnt_id  = {ID_W{1'b0}};
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx_v = (int'(ptr) + i) % NUM_SRC;
            if (!gnt_any && req[idx_v]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx_v);
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/audio_stream_arbiter.sv
// ----------------------------------------------------------------------------
// audio_stream_arbiter
// Round-robin burst arbiter feeding the single stream input of the audio
// stream-to-bus FIFO bridge. One source is granted at a time for at most
// BURST_MAX accepted words; the datapath is combinational, the grant is
// registered. At least one IDLE cycle separates consecutive grants.
// Optional feature macro: AUDIO_ARB_STATS_EN (per-source saturating counters).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             allow new grants; dropping it releases after this cycle
//   src_valid/src_data per-source word handshake inputs
//   src_ready          per-source accept (one-hot or zero)
//   out_valid/out_data/out_ready  stream towards the bridge
//   grant_id, busy     current/last granted source, GRANT-state flag
//   stat_sel, stat_clr, stat_count  accepted-word statistics access
// ----------------------------------------------------------------------------
module audio_stream_arbiter
    import audio_arb_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int DATA_SIZE = 28,
    parameter int BURST_MAX = 4,
    parameter int SRC_ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [NUM_SRC-1:0]                 src_valid,
    input  logic [NUM_SRC-1:0][DATA_SIZE-1:0]  src_data,
    output logic [NUM_SRC-1:0]                 src_ready,
    output logic                               out_valid,
    output logic [DATA_SIZE-1:0]               out_data,
    input  logic                               out_ready,
    output logic [SRC_ID_W-1:0]                grant_id,
    output logic                               busy,
    input  logic [SRC_ID_W-1:0]                stat_sel,
    input  logic                               stat_clr,
    output logic [STAT_W-1:0]                  stat_count
);

    localparam int CNT_W = 8;

    arb_state_t           state_q, state_d;
    logic [SRC_ID_W-1:0]  grant_id_q, grant_id_d;
    logic [SRC_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;

    logic                 busy_s;
    logic                 beat_s;
    logic                 grant_valid_s;
    logic                 release_s;
    logic [SRC_ID_W-1:0]  pick_id_s;
    logic                 pick_any_s;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (SRC_ID_W)
    ) u_rr_pick (
        .req     (src_valid),
        .ptr     (rr_ptr_q),
        .gnt_id  (pick_id_s),
        .gnt_any (pick_any_s)
    );

    assign busy_s        = (state_q == GRANT);
    assign grant_valid_s = src_valid[grant_id_q];
    assign busy          = busy_s;
    assign grant_id      = grant_id_q;
    assign beat_s        = out_valid && out_ready;

    // Zero-cycle datapath; the handshake is suppressed while reset is asserted
    // so no beat can complete on the reset cycle.
    always_comb begin
        src_ready = {NUM_SRC{1'b0}};
        out_valid = 1'b0;
        out_data  = {DATA_SIZE{1'b0}};
        if (busy_s) begin
            out_data  = src_data[grant_id_q];
            out_valid = grant_valid_s && !rst;
            if (out_ready && !rst) begin
                src_ready[grant_id_q] = 1'b1;
            end else begin
                src_ready = {NUM_SRC{1'b0}};
            end
        end else begin
            out_data = {DATA_SIZE{1'b0}};
        end
    end

    // Next-state logic: grant from IDLE, count/terminate bursts in GRANT.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        release_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_any_s) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_id_s;
                    burst_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (beat_s) begin
                    // A completed beat always counts, even on the release cycle.
                    if ((burst_cnt_q == CNT_W'(BURST_MAX - 1)) || !enable) begin
                        release_s = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (!grant_valid_s || !enable) begin
                    // Idle grants are never held; backpressure alone never rotates.
                    release_s = 1'b1;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_s) begin
            state_d     = IDLE;
            burst_cnt_d = {CNT_W{1'b0}};
            if (grant_id_q == SRC_ID_W'(NUM_SRC - 1)) begin
                rr_ptr_d = {SRC_ID_W{1'b0}};
            end else begin
                rr_ptr_d = grant_id_q + {{(SRC_ID_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rr_ptr_d = rr_ptr_d;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_id_q  <= {SRC_ID_W{1'b0}};
            rr_ptr_q    <= {SRC_ID_W{1'b0}};
            burst_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef AUDIO_ARB_STATS_EN
    logic [NUM_SRC-1:0][STAT_W-1:0] stat_cnt_q, stat_cnt_d;

    // Counter update: clear wins over a simultaneous beat.
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (stat_clr) begin
            stat_cnt_d = {(NUM_SRC*STAT_W){1'b0}};
        end else if (beat_s) begin
            stat_cnt_d[grant_id_q] = sat_inc(stat_cnt_q[grant_id_q]);
        end else begin
            stat_cnt_d = stat_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_q <= {(NUM_SRC*STAT_W){1'b0}};
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    // Read mux; out-of-range selects read zero.
    always_comb begin
        stat_count = {STAT_W{1'b0}};
        if (int'(stat_sel) < NUM_SRC) begin
            stat_count = stat_cnt_q[stat_sel];
        end else begin
            stat_count = {STAT_W{1'b0}};
        end
    end
`else
    logic stat_unused_s;
    assign stat_unused_s = ^{stat_sel, stat_clr};
    assign stat_count    = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_audio_stream_arbiter.sv
module tb_audio_stream_arbiter;

    localparam logic [27:0] D0 = 28'h1234567;
    localparam logic [27:0] D1 = 28'h0ABCDEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [1:0]        src_valid;
    logic [1:0][27:0]  src_data;
    logic [1:0]        src_ready;
    logic              out_valid;
    logic [27:0]       out_data;
    logic              out_ready;
    logic [0:0]        grant_id;
    logic              busy;
    logic [0:0]        stat_sel;
    logic              stat_clr;
    logic [15:0]       stat_count;

    int n_vec = 0;
    int n_err = 0;

    audio_stream_arbiter #(
        .NUM_SRC   (2),
        .DATA_SIZE (28),
        .BURST_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  sv;
        logic        rdy;
        logic        busy;
        logic        gid;
        logic        ov;
        logic [1:0]  srdy;
        logic [27:0] od;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic r, logic e, logic [1:0] s, logic rd,
                               logic b, logic g, logic o, logic [1:0] sr, logic [27:0] d);
        vec_t t;
        t.rst = r; t.en = e; t.sv = s; t.rdy = rd;
        t.busy = b; t.gid = g; t.ov = o; t.srdy = sr; t.od = d;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; src_valid = 2'b00; out_ready = 1'b0;
        src_data[0] = D0; src_data[1] = D1;
        stat_sel = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge clk);

        // reset, then both valid: bursts of 4 alternate 0,1,0 with one idle gap
        vq.push_back(v(1,1,2'b11,1, 0,0,0,2'b00,28'h0));
        vq.push_back(v(0,1,2'b11,1, 0,0,0,2'b00,28'h0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        vq.push_back(v(0,1,2'b11,1, 0,0,0,2'b00,28'h0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,1,2'b11,1, 1,1,1,2'b10,D1));
        vq.push_back(v(0,1,2'b11,1, 0,1,0,2'b00,28'h0));
        // one beat, then 10 cycles of backpressure, then 3 more beats
        vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        for (int i = 0; i < 10; i++) vq.push_back(v(0,1,2'b11,0, 1,0,1,2'b00,D0));
        for (int i = 0; i < 3; i++) vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        // only src1 valid: granted, re-granted after one idle cycle
        vq.push_back(v(0,1,2'b10,1, 0,0,0,2'b00,28'h0));
        for (int i = 0; i < 4; i++) vq.push_back(v(0,1,2'b10,1, 1,1,1,2'b10,D1));
        vq.push_back(v(0,1,2'b10,1, 0,1,0,2'b00,28'h0));
        // granted src1 drops valid -> immediate release, rr_ptr wraps to 0
        vq.push_back(v(0,1,2'b01,1, 1,1,0,2'b10,D1));
        vq.push_back(v(0,1,2'b11,1, 0,1,0,2'b00,28'h0));
        // src0: two beats then drops valid -> release, src1 next
        vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        vq.push_back(v(0,1,2'b10,1, 1,0,0,2'b01,D0));
        vq.push_back(v(0,1,2'b11,1, 0,0,0,2'b00,28'h0));
        vq.push_back(v(0,1,2'b11,1, 1,1,1,2'b10,D1));
        // enable drops mid-burst: beat still taken, then no grants
        vq.push_back(v(0,0,2'b11,1, 1,1,1,2'b10,D1));
        vq.push_back(v(0,0,2'b11,1, 0,1,0,2'b00,28'h0));
        vq.push_back(v(0,0,2'b11,1, 0,1,0,2'b00,28'h0));
        vq.push_back(v(0,1,2'b11,1, 0,1,0,2'b00,28'h0));
        vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));
        // reset mid-burst: no handshake on reset cycle, idle afterwards
        vq.push_back(v(1,1,2'b11,1, 1,0,0,2'b00,D0));
        vq.push_back(v(0,1,2'b11,1, 0,0,0,2'b00,28'h0));
        vq.push_back(v(0,1,2'b11,1, 1,0,1,2'b01,D0));

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; enable = vq[i].en; src_valid = vq[i].sv; out_ready = vq[i].rdy;
            stat_sel = 1'(i % 2);
            #2;
            n_vec++;
            chk("busy",      i, 32'(busy),      32'(vq[i].busy));
            chk("grant_id",  i, 32'(grant_id),  32'(vq[i].gid));
            chk("out_valid", i, 32'(out_valid), 32'(vq[i].ov));
            chk("src_ready", i, 32'(src_ready), 32'(vq[i].srdy));
            chk("out_data",  i, 32'(out_data),  32'(vq[i].od));
`ifndef AUDIO_ARB_STATS_EN
            chk("stat_zero", i, 32'(stat_count), 32'h0);
`endif
        end

`ifdef AUDIO_ARB_STATS_EN
        // saturation: ~65600 beats on src0 exceed the 16-bit range
        @(negedge clk);
        rst = 1'b1; enable = 1'b1; src_valid = 2'b01; out_ready = 1'b1; stat_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2; n_vec++; chk("stat_after_rst", 0, 32'(stat_count), 32'h0);
        repeat (82000) @(negedge clk);
        #2; n_vec++; chk("stat_saturated", 1, 32'(stat_count), 32'hFFFF);
        stat_sel = 1'b1;
        #1; n_vec++; chk("stat_src1", 2, 32'(stat_count), 32'h0);
        stat_sel = 1'b0;
        // clear while beats keep flowing: the coincident beat is not counted
        @(negedge clk);
        while (!(out_valid && out_ready)) @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0; src_valid = 2'b00;
        #2; n_vec++; chk("stat_clr", 3, 32'(stat_count), 32'h0);
`else
        @(negedge clk);
        stat_clr = 1'b1; stat_sel = 1'b0;
        #2; n_vec++; chk("stat_tied", 0, 32'(stat_count), 32'h0);
        stat_clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
